// File: rtl/inner_product_pkg.sv
// rtl/inner_product_pkg.sv - shared widths and helpers for the inner-product datapath (INNER_PRODUCT_SAT_EN selects saturating narrow)
package inner_product_pkg;

    localparam int DEF_BIT_WIDTH = 8;
    localparam int DEF_LANES     = 4;
    localparam int DEF_VEC_LEN   = 16;
    localparam int DEF_FRAC_BITS = 6;

    function automatic int acc_width(input int bitWidth, input int vecLen);
        return 2 * bitWidth + $clog2(vecLen);
    endfunction

    // Result lives in the low bw bits, sign-extended to 64; caller slices it.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v, input int unsigned bw);
`ifdef INNER_PRODUCT_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - bw)) >>> (64 - bw);
`endif
    endfunction

endpackage

// File: rtl/lane_mac_tree.sv
// rtl/lane_mac_tree.sv - combinational LANES-wide signed multiply and sum into ACC_WIDTH
module lane_mac_tree
    import inner_product_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int ACC_WIDTH = acc_width(DEF_BIT_WIDTH, DEF_VEC_LEN)
) (
    input  logic [LANES*BIT_WIDTH-1:0] iW,
    input  logic [LANES*BIT_WIDTH-1:0] iX,
    output logic signed [ACC_WIDTH-1:0] oPsum
);

    logic signed [2*BIT_WIDTH-1:0] prod [LANES];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod[k] = $signed(iW[k*BIT_WIDTH +: BIT_WIDTH]) * $signed(iX[k*BIT_WIDTH +: BIT_WIDTH]);
        end
    end

    always_comb begin
        oPsum = '0;
        for (int k = 0; k < LANES; k++) begin
            oPsum = oPsum + ACC_WIDTH'(prod[k]);
        end
    end

endmodule

// File: rtl/inner_product_seq.sv
// rtl/inner_product_seq.sv - time-multiplexed dot product with product/accumulate stages (INNER_PRODUCT_SAT_EN selects saturation)
module inner_product_seq
    import inner_product_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int VEC_LEN   = DEF_VEC_LEN,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_WIDTH = acc_width(BIT_WIDTH, VEC_LEN)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic [LANES*BIT_WIDTH-1:0] iW,
    input  logic [LANES*BIT_WIDTH-1:0] iX,
    input  logic                       iClear,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [BIT_WIDTH-1:0]       oInnerout
);

    localparam int NBEATS = VEC_LEN / LANES;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [CW-1:0]               beatCnt;
    logic                        pValid;
    logic                        pFirst;
    logic                        pLast;
    logic signed [ACC_WIDTH-1:0] pSum;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] treeSum;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        stall;
    logic                        accept;
    logic                        cntLast;

    lane_mac_tree #(
        .BIT_WIDTH(BIT_WIDTH),
        .LANES    (LANES),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_tree (
        .iW   (iW),
        .iX   (iX),
        .oPsum(treeSum)
    );

    // Only a finished vector waiting behind an unaccepted result blocks the pipe.
    assign stall   = pValid & pLast & oValid & ~iReady;
    assign oReady  = ~stall;
    assign accept  = iValid & oReady & ~iClear;
    assign cntLast = (beatCnt == CW'(NBEATS - 1));
    assign sum     = (pFirst ? '0 : acc) + pSum;
    assign shifted = sum >>> FRAC_BITS;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beatCnt   <= '0;
            pValid    <= 1'b0;
            pFirst    <= 1'b0;
            pLast     <= 1'b0;
            pSum      <= '0;
            acc       <= '0;
            oValid    <= 1'b0;
            oInnerout <= '0;
        end else begin
            if (iClear) begin
                beatCnt <= '0;
                pValid  <= 1'b0;
                acc     <= '0;
            end else if (!stall) begin
                pValid <= accept;
                if (accept) begin
                    pSum    <= treeSum;
                    pFirst  <= (beatCnt == '0);
                    pLast   <= cntLast;
                    beatCnt <= cntLast ? '0 : beatCnt + 1'b1;
                end
                if (pValid) begin
                    acc <= pLast ? '0 : sum;
                end
            end

            // A new result loading wins over the downstream accept clearing oValid.
            if (!iClear && !stall && pValid && pLast) begin
                oValid    <= 1'b1;
                oInnerout <= BIT_WIDTH'(narrow(64'(shifted), BIT_WIDTH));
            end else if (iReady) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inner_product_seq.sv
// tb/tb_inner_product_seq.sv - directed table and sequence checks for inner_product_seq
module tb_inner_product_seq;

    localparam int BW    = 8;
    localparam int LANES = 4;
    localparam int LW    = LANES * BW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          iValid;
    logic          oReady;
    logic [LW-1:0] iW;
    logic [LW-1:0] iX;
    logic          iClear;
    logic          oValid;
    logic          iReady;
    logic [BW-1:0] oInnerout;

    int nCompared = 0;
    int nMismatched = 0;

    inner_product_seq dut (
        .clk      (clk),
        .resetn   (resetn),
        .iValid   (iValid),
        .oReady   (oReady),
        .iW       (iW),
        .iX       (iX),
        .iClear   (iClear),
        .oValid   (oValid),
        .iReady   (iReady),
        .oInnerout(oInnerout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [BW-1:0] w;
        logic [BW-1:0] x;
        logic [BW-1:0] expWrap;
        logic [BW-1:0] expSat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveBeat(input logic [LW-1:0] w, input logic [LW-1:0] x);
        int budget = 0;
        @(negedge clk);
        iValid = 1'b1;
        iW = w;
        iX = x;
        while (!oReady && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!oReady) check("ready_timeout", 32'(oReady), 32'd1);
    endtask

    task automatic runVector(input string name, input logic [BW-1:0] w, input logic [BW-1:0] x,
                             input logic [BW-1:0] exp);
        for (int b = 0; b < 4; b++) driveBeat({LANES{w}}, {LANES{x}});
        @(negedge clk);
        iValid = 1'b0;
        check({name, "_not_early"}, 32'(oValid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(oValid), 32'd1);
        check({name, "_data"}, 32'(oInnerout), 32'(exp));
    endtask

    vec_t tbl [8];

    initial begin
        logic [LW-1:0] mixW;
        logic [BW-1:0] expV;

        tbl[0] = '{"pos8",     8'd8,    8'd8,    8'h10, 8'h10};
        tbl[1] = '{"neg8",     8'hF8,   8'd8,    8'hF0, 8'hF0};
        tbl[2] = '{"pos64",    8'd64,   8'd64,   8'h00, 8'h7F};
        tbl[3] = '{"neg64",    8'hC0,   8'd64,   8'h00, 8'h80};
        tbl[4] = '{"floor_m1", 8'hFF,   8'd1,    8'hFF, 8'hFF};
        tbl[5] = '{"small",    8'd5,    8'd3,    8'h03, 8'h03};
        tbl[6] = '{"max127",   8'd127,  8'd127,  8'hC0, 8'h7F};
        tbl[7] = '{"min128",   8'h80,   8'h80,   8'h00, 8'h7F};

        resetn = 1'b0;
        iValid = 1'b0;
        iW = '0;
        iX = '0;
        iClear = 1'b0;
        iReady = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset_oValid", 32'(oValid), 32'd0);
        check("reset_oInnerout", 32'(oInnerout), 32'd0);
        check("reset_oReady", 32'(oReady), 32'd1);

        foreach (tbl[i]) begin
`ifdef INNER_PRODUCT_SAT_EN
            expV = tbl[i].expSat;
`else
            expV = tbl[i].expWrap;
`endif
            runVector(tbl[i].name, tbl[i].w, tbl[i].x, expV);
        end

        // Lane k weight k+1, beat b activation 8*(b+1): 10*80 = 800, >>>6 = 12
        mixW = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int b = 0; b < 4; b++) driveBeat(mixW, {LANES{8'(8 * (b + 1))}});
        @(negedge clk);
        iValid = 1'b0;
        @(negedge clk);
        check("mixed_valid", 32'(oValid), 32'd1);
        check("mixed_data", 32'(oInnerout), 32'h0C);

        // Back-pressure: two vectors streamed with iReady low
        @(negedge clk);
        iReady = 1'b0;
        for (int b = 0; b < 4; b++) driveBeat({LANES{8'd8}}, {LANES{8'd8}});
        for (int b = 0; b < 4; b++) driveBeat({LANES{8'hF8}}, {LANES{8'd8}});
        @(negedge clk);
        iValid = 1'b0;
        check("stall_oReady_low", 32'(oReady), 32'd0);
        check("stall_first_valid", 32'(oValid), 32'd1);
        check("stall_first_data", 32'(oInnerout), 32'h10);
        repeat (3) @(negedge clk);
        check("stall_hold_valid", 32'(oValid), 32'd1);
        check("stall_hold_data", 32'(oInnerout), 32'h10);
        check("stall_hold_ready", 32'(oReady), 32'd0);
        iReady = 1'b1;
        @(negedge clk);
        check("release_valid", 32'(oValid), 32'd1);
        check("release_data", 32'(oInnerout), 32'hF0);
        check("release_ready", 32'(oReady), 32'd1);
        @(negedge clk);
        check("release_drain", 32'(oValid), 32'd0);

        // Clear after two beats; a beat presented with iClear is ignored
        driveBeat({LANES{8'd5}}, {LANES{8'd3}});
        driveBeat({LANES{8'd5}}, {LANES{8'd3}});
        @(negedge clk);
        iClear = 1'b1;
        iW = {LANES{8'd100}};
        iX = {LANES{8'd100}};
        @(negedge clk);
        iClear = 1'b0;
        iValid = 1'b0;
        runVector("after_clear", 8'd8, 8'd8, 8'h10);

        // Clear while the last beat sits in the product stage discards it
        @(negedge clk);
        for (int b = 0; b < 4; b++) driveBeat({LANES{8'hF8}}, {LANES{8'd8}});
        @(negedge clk);
        iValid = 1'b0;
        iClear = 1'b1;
        @(negedge clk);
        iClear = 1'b0;
        check("inflight_clear_v0", 32'(oValid), 32'd0);
        @(negedge clk);
        check("inflight_clear_v1", 32'(oValid), 32'd0);
        check("inflight_clear_data", 32'(oInnerout), 32'h10);

        // Asynchronous reset mid-vector with a held result
        iReady = 1'b0;
        runVector("pre_reset", 8'd8, 8'd8, 8'h10);
        driveBeat({LANES{8'd5}}, {LANES{8'd3}});
        driveBeat({LANES{8'd5}}, {LANES{8'd3}});
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_oValid", 32'(oValid), 32'd0);
        check("async_reset_oInnerout", 32'(oInnerout), 32'd0);
        check("async_reset_oReady", 32'(oReady), 32'd1);
        iValid = 1'b0;
        iReady = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        runVector("after_reset", 8'd8, 8'd8, 8'h10);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
